// File: rtl/qc_ldpc_enc_serial_if.sv
// qc_ldpc_enc_serial_if: seed config, message and codeword handshake bundle; out_data widens with SYSTEMATIC_OUT_EN
interface qc_ldpc_enc_serial_if #(
  parameter int Z  = 27,
  parameter int KB = 1,
  parameter int MB = 6,
  parameter int AW = 3
);
  localparam int K = KB * Z;
  localparam int P = MB * Z;
`ifdef SYSTEMATIC_OUT_EN
  localparam int OUT_W = K + P;
`else
  localparam int OUT_W = P;
`endif
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [Z-1:0]     cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/qc_ldpc_enc_serial.sv
// qc_ldpc_enc_serial: bit-serial QC-LDPC parity encoder from stored circulant seeds; SYSTEMATIC_OUT_EN prepends the message to out_data
module qc_ldpc_enc_serial #(
  parameter int Z  = 27,
  parameter int KB = 1,
  parameter int MB = 6,
  parameter int AW = 3
) (
  input logic                 clk,
  input logic                 rst,
  qc_ldpc_enc_serial_if.slave bus
);
  localparam int K  = KB * Z;
  localparam int P  = MB * Z;
  localparam int CW = $clog2(K + 1);
  localparam int JW = $clog2(Z + 1);
`ifdef SYSTEMATIC_OUT_EN
  localparam int OUT_W = K + P;
`else
  localparam int OUT_W = P;
`endif
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t               r_state, w_next;
  logic [Z-1:0]         r_seed [2**AW];
  logic [K-1:0]         r_msg;
  logic [MB-1:0][Z-1:0] r_acc, r_rot, w_acc_nx, w_rot_nx;
  logic [CW-1:0]        r_cnt;
  logic [JW-1:0]        r_j;
  logic [AW-1:0]        r_sidx;
  logic [OUT_W-1:0]     r_out;
  logic                 w_last, w_wrap;
  assign bus.out_data = r_out;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state and handshake outputs
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = ENC;
      end
      ENC: if (w_last) w_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // accumulate the current circulant row per parity block and advance it; block boundaries reload the next block's seed
  always_comb begin
    w_last = r_cnt == CW'(K - 1);
    w_wrap = r_j == JW'(Z - 1);
    for (int m = 0; m < MB; m++) begin
      w_acc_nx[m] = r_msg[r_cnt] ? r_acc[m] ^ r_rot[m] : r_acc[m];
      w_rot_nx[m] = w_wrap ? r_seed[r_sidx + AW'(m)] : {r_rot[m][Z-2:0], r_rot[m][Z-1]};
    end
  end
  // seed table, message latch, accumulators, bit counters and held codeword
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 2**AW; a++) r_seed[a] <= '0;
      r_msg  <= '0;
      r_acc  <= '0;
      r_rot  <= '0;
      r_cnt  <= '0;
      r_j    <= '0;
      r_sidx <= '0;
      r_out  <= '0;
    end else if (r_state == IDLE) begin
      if (bus.cfg_we && 32'(bus.cfg_addr) < KB * MB) r_seed[bus.cfg_addr] <= bus.cfg_data;
      if (bus.in_valid) begin
        r_msg  <= bus.in_data;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_j    <= '0;
        r_sidx <= AW'(MB);
        for (int m = 0; m < MB; m++) r_rot[m] <= r_seed[AW'(m)];
      end
    end else if (r_state == ENC) begin
      r_acc <= w_acc_nx;
      r_rot <= w_rot_nx;
      r_cnt <= r_cnt + 1'b1;
      r_j   <= w_wrap ? '0 : r_j + 1'b1;
      if (w_wrap) r_sidx <= r_sidx + AW'(MB);
`ifdef SYSTEMATIC_OUT_EN
      if (w_last) r_out <= {w_acc_nx, r_msg};
`else
      if (w_last) r_out <= w_acc_nx;
`endif
    end
  end
endmodule

// File: tb/tb_qc_ldpc_enc_serial.sv
// tb_qc_ldpc_enc_serial: scoreboard bench for a KB=1 and a KB=2 encoder against a direct GF(2) circulant model
module tb_qc_ldpc_enc_serial;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0, cyc = 0, acc_a = 0, acc_b = 0, rmode = 2;
  typedef logic [26:0] st_t [16];
  st_t sa, sb;
  logic [215:0] qa[$], qb[$];
  logic pva = 0, pvb = 0;

  qc_ldpc_enc_serial_if #(.Z(27), .KB(1), .MB(6), .AW(3)) ifa();
  qc_ldpc_enc_serial_if #(.Z(27), .KB(2), .MB(6), .AW(4)) ifb();
  qc_ldpc_enc_serial #(.Z(27), .KB(1), .MB(6), .AW(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  qc_ldpc_enc_serial #(.Z(27), .KB(2), .MB(6), .AW(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    ifa.out_ready = rmode == 0 ? ($urandom % 2) == 1 : rmode == 2;
    ifb.out_ready = rmode == 0 ? ($urandom % 2) == 1 : rmode == 2;
  end

  task automatic chk(input string n, input logic [215:0] a, input logic [215:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  // Message bit i selects row i%27 of circulant (i/27, mb): seed shifted up by i%27, cyclically.
  function automatic logic [215:0] exp_f(input st_t s, input logic [53:0] m, input int nkb);
    logic [161:0] p = '0;
    logic [215:0] e;
    for (int i = 0; i < nkb * 27; i++)
      if (m[i])
        for (int mb = 0; mb < 6; mb++)
          for (int k = 0; k < 27; k++)
            if (s[(i / 27) * 6 + mb][k]) p[mb * 27 + (k + i % 27) % 27] ^= 1'b1;
    e = 216'(p);
`ifdef SYSTEMATIC_OUT_EN
    e = (e << (nkb * 27)) | 216'(m);
`endif
    return e;
  endfunction

  task automatic cfg_a(input int addr, input logic [26:0] d, input bit upd);
    @(posedge clk); #1;
    ifa.cfg_we = 1; ifa.cfg_addr = 3'(addr); ifa.cfg_data = d;
    @(posedge clk); #1;
    ifa.cfg_we = 0;
    if (upd && addr < 6) sa[addr] = d;
  endtask

  task automatic cfg_b(input int addr, input logic [26:0] d);
    @(posedge clk); #1;
    ifb.cfg_we = 1; ifb.cfg_addr = 4'(addr); ifb.cfg_data = d;
    @(posedge clk); #1;
    ifb.cfg_we = 0;
    if (addr < 12) sb[addr] = d;
  endtask

  task automatic enc_a(input logic [26:0] m);
    int t = 0;
    @(posedge clk); #1;
    ifa.in_valid = 1; ifa.in_data = m;
    @(negedge clk);
    while (!ifa.in_ready && t < 300) begin @(negedge clk); t++; end
    if (!ifa.in_ready) chk("a_accept_timeout", 216'(ifa.in_ready), 216'(1));
    else begin qa.push_back(exp_f(sa, 54'(m), 1)); acc_a = cyc + 1; end
    @(posedge clk); #1;
    ifa.in_valid = 0;
  endtask

  task automatic enc_b(input logic [53:0] m);
    int t = 0;
    @(posedge clk); #1;
    ifb.in_valid = 1; ifb.in_data = m;
    @(negedge clk);
    while (!ifb.in_ready && t < 300) begin @(negedge clk); t++; end
    if (!ifb.in_ready) chk("b_accept_timeout", 216'(ifb.in_ready), 216'(1));
    else begin qb.push_back(exp_f(sb, m, 2)); acc_b = cyc + 1; end
    @(posedge clk); #1;
    ifb.in_valid = 0;
  endtask

  task automatic idle_a;
    int t = 0;
    while ((qa.size() != 0 || !ifa.in_ready) && t < 500) begin @(negedge clk); t++; end
    if (qa.size() != 0) chk("a_drain_timeout", 216'(qa.size()), 216'(0));
  endtask

  task automatic idle_b;
    int t = 0;
    while ((qb.size() != 0 || !ifb.in_ready) && t < 500) begin @(negedge clk); t++; end
    if (qb.size() != 0) chk("b_drain_timeout", 216'(qb.size()), 216'(0));
  endtask

  always @(negedge clk) begin
    if (rst) pva = 0;
    else begin
      if (ifa.out_valid) begin
        if (!pva) chk("a_latency", 216'(cyc - acc_a), 216'(27));
        chk("a_in_ready_busy", 216'(ifa.in_ready), 216'(0));
        if (qa.size() == 0) chk("a_spurious_valid", 216'(ifa.out_valid), 216'(0));
        else begin
          chk("a_data", 216'(ifa.out_data), qa[0]);
          if (ifa.out_ready) void'(qa.pop_front());
        end
      end
      pva = ifa.out_valid;
    end
  end

  always @(negedge clk) begin
    if (rst) pvb = 0;
    else begin
      if (ifb.out_valid) begin
        if (!pvb) chk("b_latency", 216'(cyc - acc_b), 216'(54));
        chk("b_in_ready_busy", 216'(ifb.in_ready), 216'(0));
        if (qb.size() == 0) chk("b_spurious_valid", 216'(ifb.out_valid), 216'(0));
        else begin
          chk("b_data", 216'(ifb.out_data), qb[0]);
          if (ifb.out_ready) void'(qb.pop_front());
        end
      end
      pvb = ifb.out_valid;
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 16; i++) begin sa[i] = '0; sb[i] = '0; end
    ifa.cfg_we = 0; ifa.cfg_addr = '0; ifa.cfg_data = '0; ifa.in_valid = 0; ifa.in_data = '0;
    ifb.cfg_we = 0; ifb.cfg_addr = '0; ifb.cfg_data = '0; ifb.in_valid = 0; ifb.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_a_in_ready", 216'(ifa.in_ready), 216'(1));
    chk("rst_a_out_valid", 216'(ifa.out_valid), 216'(0));
    chk("rst_a_out_data", 216'(ifa.out_data), 216'(0));
    chk("rst_b_out_data", 216'(ifb.out_data), 216'(0));
    for (int m = 0; m < 6; m++) cfg_a(m, 27'(1) << m, 1);
    cfg_a(6, '1, 1);
    cfg_a(7, '1, 1);
    enc_a(27'h1);
    enc_a(27'h1 << 26);
    enc_a(27'h7FFFFFF);
    enc_a(27'h0);
    idle_a();
    rmode = 1;
    enc_a(27'($urandom));
    t = 0;
    while (!ifa.out_valid && t < 100) begin @(negedge clk); t++; end
    chk("a_bp_valid", 216'(ifa.out_valid), 216'(1));
    cfg_a(0, 27'h5A5A5A5, 0);
    repeat (3) @(posedge clk);
    #1 rmode = 2;
    idle_a();
    enc_a(27'($urandom));
    idle_a();
    rmode = 0;
    repeat (12) begin
      if ($urandom % 3 == 0) begin
        idle_a();
        for (int m = 0; m < 6; m++) cfg_a(m, 27'($urandom), 1);
      end
      enc_a(27'($urandom));
    end
    idle_a();
    rmode = 2;
    cfg_b(0, 27'h1);
    cfg_b(6, 27'h2);
    enc_b(54'(1) << 27);
    enc_b((54'(1) << 27) | 54'(1));
    idle_b();
    for (int i = 0; i < 12; i++) cfg_b(i, 27'($urandom));
    rmode = 0;
    repeat (6) enc_b(54'({$urandom, $urandom}));
    idle_b();
    rmode = 2;
    idle_a();
    enc_a(27'($urandom) | 27'h1);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    qa.delete();
    for (int i = 0; i < 16; i++) begin sa[i] = '0; sb[i] = '0; end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_in_ready", 216'(ifa.in_ready), 216'(1));
    chk("abort_out_valid", 216'(ifa.out_valid), 216'(0));
    repeat (40) @(negedge clk);
    enc_a(27'($urandom));
    idle_a();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
